// File: rtl/mont_encoder.sv
// rtl/mont_encoder.sv - plain integer to Montgomery form converter, c = x * 2^R_LOG2 mod N
module mont_encoder #(
    parameter int WIDTH  = 512,
    parameter int R_LOG2 = WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] modulo,
    input  logic             use_one,
    input  logic             valid_in,
    output logic [WIDTH-1:0] c_out,
    output logic             valid_out,
    output logic             busy_out
);

    localparam int CNT_W = $clog2(R_LOG2 + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(R_LOG2 - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PREREDUCE = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    // acc carries one spare bit so the doubled value never overflows
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] n_reg;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   n_ext;
    logic [WIDTH:0]   acc_red;
    logic [WIDTH:0]   dbl;
    logic [WIDTH:0]   dbl_red;

    // conditional-subtract datapath: one pre-reduction and one doubling step
    always_comb begin
        n_ext   = {1'b0, n_reg};
        acc_red = (acc >= n_ext) ? acc - n_ext : acc;
        dbl     = {acc[WIDTH-1:0], 1'b0};
        dbl_red = (dbl >= n_ext) ? dbl - n_ext : dbl;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (valid_in) state_nxt = PREREDUCE;
            PREREDUCE: state_nxt = SHIFT;
            SHIFT:     if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // operand capture, iterative doubling and registered result/handshake
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            acc       <= '0;
            n_reg     <= '0;
            cnt       <= '0;
            c_out     <= '0;
            valid_out <= 1'b0;
            busy_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid_out <= 1'b0;
                    if (valid_in) begin
                        acc      <= use_one ? (WIDTH+1)'(1) : {1'b0, x_in};
                        n_reg    <= modulo;
                        busy_out <= 1'b1;
                    end
                end
                PREREDUCE: begin
                    // brings x into [0, N) so each doubling needs one subtract
                    acc <= acc_red;
                    cnt <= '0;
                end
                SHIFT: begin
                    acc <= dbl_red;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        c_out     <= dbl_red[WIDTH-1:0];
                        valid_out <= 1'b1;
                        busy_out  <= 1'b0;
                    end
                end
                DONE: begin
                    valid_out <= 1'b0;
                end
                default: begin
                    valid_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mont_encoder.md
Name: mont_encoder

Overview:
Sequential converter from plain integers into Montgomery form: c = x·2^R_LOG2 mod N. It produces the Montgomery-form base and the Montgomery form of 1 that mod_exponent consumes, as its base and start_product inputs. It is the entry direction of the Montgomery domain; mont_reduction handles the exit. It uses repeated double-and-conditional-subtract, with no multiplier, so area is small and latency is deterministic.

Parameters:
WIDTH, 512, operand and modulus width in bits.
R_LOG2, WIDTH, log2 of the Montgomery radix R. Must match the R fed to mod_exponent.

Ports:
clk_in  input  1  clock.
rst_in  input  1  asynchronous active-high reset.
x_in  input  WIDTH  plain operand. Sampled on the accept edge.
modulo  input  WIDTH  modulus N. Sampled on the accept edge.
use_one  input  1  when high at accept, x_in is ignored and x is taken as 1 (computes R mod N).
valid_in  input  1  request strobe.
c_out  output  WIDTH  result x·R mod N. Held until the next result.
valid_out  output  1  one-cycle pulse marking c_out valid.
busy_out  output  1  high while a conversion is in flight.

Behaviour:
- Reset: rst_in asynchronous, active-high.
  - While asserted: state=IDLE, c_out=0, valid_out=0, busy_out=0, accumulator=0, counter=0.
  - Mid-operation reset aborts the conversion with no valid_out. The first valid_in after release starts fresh.
- Registers:
  - acc: WIDTH+1 bits, so the doubled value cannot overflow.
  - n_reg: WIDTH bits.
  - cnt: clog2(R_LOG2+1) bits.
- States and transitions:
  - IDLE:
    - On valid_in=1: capture x (x_in, or 1 if use_one) into acc and modulo into n_reg; busy_out<=1; go to PREREDUCE. This edge is the accept edge, edge 0.
    - valid_in is ignored in every other state; no queuing.
  - PREREDUCE (edge 1): acc <= (acc >= n_reg) ? acc - n_reg : acc; cnt<=0; go to SHIFT.
  - SHIFT (edges 2..R_LOG2+1): each edge computes t = acc<<1, then acc <= (t >= n_reg) ? t - n_reg : t, and cnt increments.
    - On the edge where cnt == R_LOG2-1 (the final doubling): c_out <= reduced value, valid_out<=1, busy_out<=0, go to DONE.
  - DONE: valid_out<=0; go to IDLE. A valid_in present in DONE is not accepted; it is accepted on the following cycle in IDLE.
- Latency:
  - valid_out is high during the cycle after edge R_LOG2+1, i.e. R_LOG2+1 clocks after the accept edge.
  - Throughput is one conversion per R_LOG2+3 cycles with valid_in held high.
- Arithmetic:
  - Invariant after PREREDUCE: acc < n_reg. It is preserved by every SHIFT step because 2·acc < 2N, so one subtract suffices.
  - Comparisons are unsigned and (WIDTH+1)-bit.
- Input constraints:
  - N must be odd and ≥3.
  - x_in must be < 2N; one pre-subtract handles N ≤ x_in < 2N.
  - Outside these ranges c_out is unspecified, but the FSM still completes with normal timing and never hangs.
- Other rules:
  - modulo and x_in may change after the accept edge without effect.
  - c_out holds its value after valid_out falls.
  - Boundary cases: x=0 gives 0; x=N gives 0; x=N-1 gives N - (R mod N), or 0 if R mod N is 0.

Test Plan:
1. WIDTH=8, R_LOG2=8, N=13, x_in=5, single valid_in pulse -> valid_out pulses exactly 9 cycles after the accept edge with c_out=6; busy_out high from edge 0 until edge 9.
2. N=13, use_one=1, x_in=0xAB -> c_out=9 (256 mod 13). Repeat with x_in=0 and use_one=0 -> c_out=0. Repeat with x_in=13 -> c_out=0.
3. N=13, x_in=20 (pre-subtract path) -> c_out=11. Then N=255, x_in=254 (exercises the 9-bit acc carry) -> c_out=254.
4. valid_in held high for 30 cycles with x_in=5, N=13 -> accepts exactly every 11 cycles; each valid_out is a single-cycle pulse with c_out=6; no accepts while busy_out=1 or in DONE.
5. Assert rst_in asynchronously (between clock edges) at cycle 4 of a conversion -> c_out, valid_out and busy_out go to 0 immediately, with no valid_out pulse. After release, a new request x_in=3, N=13 -> c_out=1 (768 mod 13) with full 9-cycle latency.
6. Change x_in and modulo on the cycle after accept (x_in=5, N=13 accepted; then drive 7 and 11) -> result is still 6.
